// File: rtl/sniffer_pkg.sv
// Shared definitions for the sniffer match-record path: register map, ID and reader FSM states.
package sniffer_pkg;

  localparam int unsigned AVS_ADDR_W = 2;

  localparam logic [AVS_ADDR_W-1:0] REG_DATA   = 2'd0;
  localparam logic [AVS_ADDR_W-1:0] REG_STATUS = 2'd1;
  localparam logic [AVS_ADDR_W-1:0] REG_CTRL   = 2'd2;
  localparam logic [AVS_ADDR_W-1:0] REG_ID     = 2'd3;

  localparam logic [31:0] ID_VALUE = 32'h534E_4652;

  localparam int unsigned CTRL_CLR_OVF_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;

  localparam int unsigned STATUS_OVF_BIT   = 31;
  localparam int unsigned STATUS_EMPTY_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESPOND  = 2'd2
  } reader_state_t;

endpackage : sniffer_pkg

// File: rtl/match_buffer_reader.sv
// Avalon-MM reader for the circular match-record memory: pops records, reports status, clears/flushes.
module match_buffer_reader
  import sniffer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              inc_addr,
  output logic              full,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              irq
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  reader_state_t     r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_irq;
  logic              r_pop;
  logic [DATA_W-1:0] r_readdata;

  reader_state_t     w_state_nxt;
  logic              w_pop_nxt;
  logic [DATA_W-1:0] w_readdata_nxt;
  logic [DATA_W-1:0] w_reg_value;
  logic              w_rden;
  logic              w_pop_now;
  logic              w_clr_ovf;
  logic              w_flush;

  logic              w_commit;
  logic [ADDR_W-1:0] w_wr_nxt;
  logic [ADDR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_overflow_nxt;

  logic              w_unused_wdata;

  // Upper write-data bits carry no CTRL function.
  assign w_unused_wdata = ^avs_writedata[DATA_W-1:2];

  // Avalon FSM: request decode, register mux, memory read launch and capture.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop_nxt      = r_pop;
    w_readdata_nxt = r_readdata;
    w_reg_value    = '0;
    w_rden         = 1'b0;
    w_pop_now      = 1'b0;
    w_clr_ovf      = 1'b0;
    w_flush        = 1'b0;

    case (avs_address)
      REG_STATUS: begin
        w_reg_value                   = DATA_W'(r_count);
        w_reg_value[STATUS_EMPTY_BIT] = (r_count == '0);
        w_reg_value[STATUS_OVF_BIT]   = r_overflow;
      end
      REG_ID:     w_reg_value = DATA_W'(ID_VALUE);
      default:    w_reg_value = '0;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (avs_read) begin
          if ((avs_address == REG_DATA) && (r_count != '0)) begin
            w_state_nxt = ST_MEM_WAIT;
            w_rden      = 1'b1;
            w_pop_nxt   = 1'b1;
          end else begin
            w_state_nxt    = ST_RESPOND;
            w_pop_nxt      = 1'b0;
            w_readdata_nxt = w_reg_value;
          end
        end else if (avs_write && (avs_address == REG_CTRL)) begin
          w_clr_ovf = avs_writedata[CTRL_CLR_OVF_BIT];
          w_flush   = avs_writedata[CTRL_FLUSH_BIT];
        end
      end
      ST_MEM_WAIT: begin
        w_state_nxt    = ST_RESPOND;
        w_readdata_nxt = mem_rdata;
      end
      ST_RESPOND: begin
        w_state_nxt = ST_IDLE;
        w_pop_now   = r_pop;
        w_pop_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pop_nxt   = 1'b0;
      end
    endcase
  end

  // Pointer/count/overflow update; a pop frees a slot for a same-cycle commit even when full.
  always_comb begin
    w_commit       = inc_addr && ((r_count != DEPTH) || w_pop_now);
    w_wr_nxt       = r_wr_ptr + ADDR_W'(w_commit);
    w_rd_nxt       = r_rd_ptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;

    if (w_flush) begin
      w_rd_nxt    = w_wr_nxt;
      w_count_nxt = CNT_W'(w_commit);
    end else begin
      if (w_pop_now) begin
        w_rd_nxt = r_rd_ptr + ADDR_W'(1);
      end
      w_count_nxt = r_count + CNT_W'(w_commit) - CNT_W'(w_pop_now);
    end

    if (inc_addr && !w_commit) begin
      w_overflow_nxt = 1'b1;
    end else if (w_clr_ovf) begin
      w_overflow_nxt = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
      r_pop      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_irq      <= (r_count != '0);
      r_pop      <= w_pop_nxt;
      r_readdata <= w_readdata_nxt;
    end
  end

  assign full            = (r_count == DEPTH);
  assign mem_rden        = w_rden;
  assign mem_raddr       = r_rd_ptr;
  assign avs_waitrequest = avs_read && (r_state != ST_RESPOND);
  assign avs_readdata    = r_readdata;
  assign irq             = r_irq;

endmodule : match_buffer_reader

// File: tb/tb_match_buffer_reader.sv
// Self-checking bench for match_buffer_reader (depth 4) against a ring-buffer reference model.
module tb_match_buffer_reader;
  import sniffer_pkg::*;

  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          inc_addr = 1'b0;
  logic          full;
  logic          mem_rden;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata = '0;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic          irq;

  match_buffer_reader #(.ADDR_W(AW), .DATA_W(32)) u_dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .inc_addr        (inc_addr),
    .full            (full),
    .mem_rden        (mem_rden),
    .mem_raddr       (mem_raddr),
    .mem_rdata       (mem_rdata),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // Record memory with a synchronous read port.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (mem_rden) mem_rdata <= mem[mem_raddr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_rd, m_wr, m_cnt;
  bit          m_ovf;
  int          g_seq;
  bit          g_seq_mode;
  int unsigned g_inc_pct;
  int          g_raddr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rand_inc();
    return ($urandom_range(99) < g_inc_pct);
  endfunction

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = 32'(m_cnt);
    s[16] = (m_cnt == 0);
    s[31] = m_ovf;
    return s;
  endfunction

  // One clock cycle: update the model from this cycle's events, advance, check flags.
  task automatic tick(input bit inc, input bit pop, input bit flush, input bit clr);
    bit          acc;
    int          pre_cnt;
    logic [31:0] v;
    inc_addr = inc;
    pre_cnt  = m_cnt;
    acc      = inc && ((m_cnt < DEPTH) || pop);
    if (acc) begin
      v = g_seq_mode ? (32'hA0 + 32'(g_seq)) : $urandom;
      g_seq++;
      mem[m_wr] = v;
      m_wr = (m_wr + 1) % DEPTH;
    end
    if (flush) begin
      m_rd  = m_wr;
      m_cnt = acc ? 1 : 0;
    end else begin
      if (pop) m_rd = (m_rd + 1) % DEPTH;
      m_cnt = m_cnt + int'(acc) - int'(pop);
    end
    if (inc && !acc) m_ovf = 1'b1;
    else if (clr)    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    inc_addr = 1'b0;
    check_eq("full", 32'(full), 32'(m_cnt == DEPTH));
    check_eq("irq", 32'(irq), 32'(pre_cnt != 0));
  endtask

  task automatic do_read(input logic [1:0] addr, input bit inc_resp, output logic [31:0] got);
    bit          is_pop;
    logic [31:0] exp;
    avs_address = addr;
    avs_read    = 1'b1;
    #1;
    is_pop = (addr == REG_DATA) && (m_cnt != 0);
    check_eq("wait_first", 32'(avs_waitrequest), 32'd1);
    check_eq("mem_rden", 32'(mem_rden), 32'(is_pop));
    if (is_pop) begin
      check_eq("mem_raddr", 32'(mem_raddr), 32'(m_rd));
      g_raddr_q.push_back(int'(mem_raddr));
      exp = mem[m_rd];
    end else begin
      case (addr)
        REG_STATUS: exp = status_exp();
        REG_ID:     exp = ID_VALUE;
        default:    exp = 32'h0;
      endcase
    end
    tick(rand_inc(), 1'b0, 1'b0, 1'b0);
    if (is_pop) begin
      check_eq("wait_mem", 32'(avs_waitrequest), 32'd1);
      tick(rand_inc(), 1'b0, 1'b0, 1'b0);
    end
    check_eq("wait_resp", 32'(avs_waitrequest), 32'd0);
    check_eq("readdata", avs_readdata, exp);
    got = avs_readdata;
    tick(inc_resp | rand_inc(), is_pop, 1'b0, 1'b0);
    avs_read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data, input bit force_inc);
    bit is_ctrl;
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    #1;
    check_eq("wait_write", 32'(avs_waitrequest), 32'd0);
    is_ctrl = (addr == REG_CTRL);
    tick(force_inc | rand_inc(), 1'b0, is_ctrl && data[1], is_ctrl && data[0]);
    avs_write = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    m_rd = 0; m_wr = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          exp_raddr [6];
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_rd = 0; m_wr = 0; m_cnt = 0; m_ovf = 1'b0;
    g_seq = 0; g_seq_mode = 1'b0; g_inc_pct = 0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_wait", 32'(avs_waitrequest), 32'd0);
    check_eq("rst_rden", 32'(mem_rden), 32'd0);
    check_eq("rst_raddr", 32'(mem_raddr), 32'd0);
    check_eq("rst_rdata", avs_readdata, 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    n_rst = 1'b1;

    // ID and STATUS after reset.
    do_read(REG_ID, 1'b0, rd);
    check_eq("id_value", rd, 32'h534E4652);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_reset", rd, 32'h00010000);

    // Three commits, three pops in order.
    g_seq_mode = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_cnt3", rd, 32'h00000003);
    for (int i = 0; i < 3; i++) begin
      do_read(REG_DATA, 1'b0, rd);
      check_eq("pop_value", rd, 32'hA0 + 32'(i));
    end
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_drained", rd, 32'h00010000);

    // Empty DATA read.
    do_read(REG_DATA, 1'b0, rd);
    check_eq("empty_data", rd, 32'h0);

    // Overflow at depth 4, then clear.
    repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_ovf", rd, 32'h80000004);
    do_write(REG_CTRL, 32'h1, 1'b0);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_clr", rd, 32'h00000004);

    // Commit during the pop cycle while full is accepted.
    do_read(REG_DATA, 1'b1, rd);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_pop_commit", rd, 32'h00000004);

    // Flush with a simultaneous commit.
    do_read(REG_DATA, 1'b0, rd);
    do_write(REG_CTRL, 32'h2, 1'b1);
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("status_flush", rd, 32'h00000001);
    do_read(REG_DATA, 1'b0, rd);

    // Pointer wrap-around from reset.
    do_reset();
    g_raddr_q.delete();
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) do_read(REG_DATA, 1'b0, rd);
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) do_read(REG_DATA, 1'b0, rd);
    exp_raddr = '{0, 1, 2, 3, 0, 1};
    check_eq("wrap_len", 32'(g_raddr_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < g_raddr_q.size(); i++)
      check_eq("wrap_raddr", 32'(g_raddr_q[i]), 32'(exp_raddr[i]));

    // Reset during MEM_WAIT loses the pop.
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0);
    avs_address = REG_DATA;
    avs_read    = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_rst    = 1'b0;
    avs_read = 1'b0;
    #1;
    check_eq("midrst_wait", 32'(avs_waitrequest), 32'd0);
    check_eq("midrst_raddr", 32'(mem_raddr), 32'd0);
    check_eq("midrst_full", 32'(full), 32'd0);
    do_reset();
    do_read(REG_STATUS, 1'b0, rd);
    check_eq("midrst_status", rd, 32'h00010000);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    do_read(REG_DATA, 1'b0, rd);

    // Randomized traffic against the model.
    g_seq_mode = 1'b0;
    g_inc_pct  = 40;
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      op = $urandom_range(9);
      if (op <= 4)      do_read(REG_DATA, 1'b0, rd);
      else if (op == 5) do_read(REG_STATUS, 1'b0, rd);
      else if (op == 6) do_read(REG_ID, 1'b0, rd);
      else if (op == 7) do_write(REG_CTRL, 32'($urandom_range(3)), 1'b0);
      else if (op == 8) do_write(2'($urandom_range(1)), $urandom, 1'b0);
      else              repeat ($urandom_range(1, 3)) tick(rand_inc(), 1'b0, 1'b0, 1'b0);
    end
    g_inc_pct = 0;
    do_read(REG_STATUS, 1'b0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_match_buffer_reader
